muldiv_unit: RTL

- Iterative multiply/divide execution unit for the RV32M extension.
- Sits directly downstream of the register file: consumes RD1/RD2 as operands and produces a write-back triple (enable, address, data) that drives the register file's write_en/A3/WD3 through the write-back mux.
- Stalls the single-cycle core via busy while an operation is in progress.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit; optional zero-operand fast path under MULDIV_ZERO_BYPASS_EN.
// Latency: XLEN+2 edges from start to wb_en; divide-by-zero, signed overflow and zero bypass take 2 edges.
// Backpressure: none; busy stalls the core, a start while busy is dropped and kill aborts CALC/FIX.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              kill,
  output logic              busy,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  // acc_hi/acc_lo: product high/low halves for multiply, remainder/quotient for divide.
  // opnd: multiplicand for multiply, divisor for divide.
  logic [2:0]      op_q;
  logic            res_neg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] opnd, acc_hi, acc_lo;

  // Operand decode at launch
  logic            is_div, a_neg, b_neg, res_neg_in, div0, ovf, zero_byp, special, accept;
  logic [XLEN-1:0] a_abs, b_abs;

  assign is_div     = op[2];
  assign a_neg      = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) && rs1_val[XLEN-1];
  assign b_neg      = (op == 3'd1 || op == 3'd4 || op == 3'd6) && rs2_val[XLEN-1];
  assign a_abs      = a_neg ? -rs1_val : rs1_val;
  assign b_abs      = b_neg ? -rs2_val : rs2_val;
  // Remainder follows the dividend; everything else follows the xor of operand signs.
  assign res_neg_in = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
  assign div0       = is_div && (rs2_val == '0);
  assign ovf        = is_div && !op[0] && (rs1_val == MOST_NEG) && (rs2_val == '1);
`ifdef MULDIV_ZERO_BYPASS_EN
  assign zero_byp   = is_div ? ((rs1_val == '0) && (rs2_val != '0))
                             : ((rs1_val == '0) || (rs2_val == '0));
`else
  assign zero_byp   = 1'b0;
`endif
  assign special    = div0 || ovf || zero_byp;
  assign accept     = start && !kill && (state == IDLE || state == DONE);

  // Iteration step values
  logic [XLEN:0]   mul_sum, div_trial;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; special results skip CALC and take a single FIX cycle to write back
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (special ? FIX : CALC) : IDLE;
      CALC:       state_nxt = kill ? IDLE : ((cnt == CW'(1)) ? FIX : CALC);
      FIX:        state_nxt = kill ? IDLE : DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy  = (state == CALC) || (state == FIX);
    wb_en = (state == DONE);
  end

  // Sign fix-up and result selection from the accumulators
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;
  always_comb begin
    prod_fix = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = res_neg ? -acc_lo : acc_lo;
    rem_fix  = res_neg ? -acc_hi : acc_hi;
    case (op_q)
      3'd0:             result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result = quo_fix;
      default:          result = rem_fix;
    endcase
  end

  // Datapath: launch capture, one bit per CALC cycle, result latch on leaving FIX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      res_neg <= 1'b0;
      cnt     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (accept) begin
      op_q    <= op;
      wb_addr <= rd_in;
      cnt     <= CW'(XLEN);
      if (special) begin
        // Preload the accumulators so FIX selects the architectural special result.
        res_neg <= 1'b0;
        opnd    <= '0;
        acc_hi  <= div0 ? rs1_val : '0;
        acc_lo  <= div0 ? '1 : (ovf ? MOST_NEG : '0);
      end else begin
        res_neg <= res_neg_in;
        acc_hi  <= '0;
        acc_lo  <= is_div ? a_abs : b_abs;
        opnd    <= is_div ? b_abs : a_abs;
      end
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (op_q[2]) begin
        if (!div_trial[XLEN]) begin
          acc_hi <= div_trial[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
        end else begin
          acc_hi <= {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
          acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi <= mul_sum[XLEN:1];
        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
      end
    end else if (state == FIX && !kill) begin
      wb_data <= result;
    end
  end

endmodule
